// File: rtl/sdram_read_fifo.sv
// Read-data FIFO behind the SDRAM read engine: 1-cycle registered pop; fifo_full asserts FULL_SLACK words early, writes to a full array are dropped.
// Optional saturating statistics counters are built when SDRAM_RFIFO_STATS_EN is defined.
module sdram_read_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int FULL_SLACK = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_wr,
  input  logic [31:0]           fifo_data,
  output logic                  fifo_full,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [15:0]           stat_words,
  output logic [15:0]           stat_drops
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH - FULL_SLACK);
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  is_full;
  logic                  wr_acc;
  logic                  wr_drop;
  logic                  pop_acc;
  logic                  pop_empty;

  assign is_full   = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign fifo_full = (count >= FULL_LEVEL);

  // flush swallows same-cycle requests, so none of these fire during it
  assign wr_acc    = fifo_wr && !is_full && !flush;
  assign wr_drop   = fifo_wr &&  is_full && !flush;
  assign pop_acc   = rd_en   && !empty   && !flush;
  assign pop_empty = rd_en   &&  empty   && !flush;

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= fifo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= pop_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({wr_acc, pop_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (wr_drop) begin
        overflow <= 1'b1;
      end
      if (pop_empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef SDRAM_RFIFO_STATS_EN
  // Saturating; only rst clears them, flush leaves history intact
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words <= '0;
      stat_drops <= '0;
    end else begin
      if (wr_acc && stat_words != 16'hFFFF) begin
        stat_words <= stat_words + 16'd1;
      end
      if (wr_drop && stat_drops != 16'hFFFF) begin
        stat_drops <= stat_drops + 16'd1;
      end
    end
  end
`else
  assign stat_words = 16'h0000;
  assign stat_drops = 16'h0000;
`endif

endmodule
